// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs,
// and issues one ready op per cycle to the combinational ALU.
module alu_rs #(
   parameter int RS_SIZE  = 16,
   parameter int RS_IDX_W = 4,
   parameter int ROB_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   input  logic             DP_sgn,
   input  logic [5:0]       DP_opcode,
   input  logic [ROB_W-1:0] DP_ROB_name,
   input  logic             DP_Qj_busy,
   input  logic [ROB_W-1:0] DP_Qj,
   input  logic [31:0]      DP_Vj,
   input  logic             DP_Qk_busy,
   input  logic [ROB_W-1:0] DP_Qk,
   input  logic [31:0]      DP_Vk,
   output logic             full,
   input  logic             ALU_CDB_sgn,
   input  logic [ROB_W-1:0] ALU_CDB_ROB_name,
   input  logic [31:0]      ALU_CDB_result,
   input  logic             LSB_CDB_sgn,
   input  logic [ROB_W-1:0] LSB_CDB_ROB_name,
   input  logic [31:0]      LSB_CDB_result,
   output logic             ALU_sgn,
   output logic [5:0]       ALU_opcode,
   output logic [ROB_W-1:0] ALU_ROB_name,
   output logic [31:0]      ALU_lhs,
   output logic [31:0]      ALU_rhs
);

   typedef struct packed {
      logic             busy;
      logic [5:0]       opcode;
      logic [ROB_W-1:0] rob_name;
      logic             qj_busy;
      logic [ROB_W-1:0] qj;
      logic [31:0]      vj;
      logic             qk_busy;
      logic [ROB_W-1:0] qk;
      logic [31:0]      vk;
   } ent_t;

   ent_t ent [RS_SIZE];

   logic [RS_SIZE-1:0]  busy_v;
   logic [RS_SIZE-1:0]  ready_v;
   logic [RS_IDX_W-1:0] free_idx;
   logic [RS_IDX_W-1:0] iss_idx;
   logic                has_ready;
   logic                dj_busy;
   logic                dk_busy;
   logic [31:0]         dj_val;
   logic [31:0]         dk_val;

   always_comb begin
      busy_v  = '0;
      ready_v = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_v[i]  = ent[i].busy;
         ready_v[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
      end
   end

   assign full = &busy_v;

   // descending scan so the lowest index wins
   always_comb begin
      free_idx  = '0;
      iss_idx   = '0;
      has_ready = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_v[i]) free_idx = RS_IDX_W'(i);
         if (ready_v[i]) begin
            iss_idx   = RS_IDX_W'(i);
            has_ready = 1'b1;
         end
      end
   end

   // operands broadcast in the dispatch cycle are captured directly
   always_comb begin
      dj_busy = DP_Qj_busy;
      dj_val  = DP_Vj;
      dk_busy = DP_Qk_busy;
      dk_val  = DP_Vk;
      if (DP_Qj_busy && ALU_CDB_sgn && DP_Qj == ALU_CDB_ROB_name) begin
         dj_busy = 1'b0;
         dj_val  = ALU_CDB_result;
      end else if (DP_Qj_busy && LSB_CDB_sgn && DP_Qj == LSB_CDB_ROB_name) begin
         dj_busy = 1'b0;
         dj_val  = LSB_CDB_result;
      end
      if (DP_Qk_busy && ALU_CDB_sgn && DP_Qk == ALU_CDB_ROB_name) begin
         dk_busy = 1'b0;
         dk_val  = ALU_CDB_result;
      end else if (DP_Qk_busy && LSB_CDB_sgn && DP_Qk == LSB_CDB_ROB_name) begin
         dk_busy = 1'b0;
         dk_val  = LSB_CDB_result;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
         ALU_sgn      <= 1'b0;
         ALU_opcode   <= '0;
         ALU_ROB_name <= '0;
         ALU_lhs      <= '0;
         ALU_rhs      <= '0;
      end else if (rdy) begin
         if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            ALU_sgn <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (ent[i].busy && ent[i].qj_busy) begin
                  if (ALU_CDB_sgn && ent[i].qj == ALU_CDB_ROB_name) begin
                     ent[i].vj      <= ALU_CDB_result;
                     ent[i].qj_busy <= 1'b0;
                  end else if (LSB_CDB_sgn && ent[i].qj == LSB_CDB_ROB_name) begin
                     ent[i].vj      <= LSB_CDB_result;
                     ent[i].qj_busy <= 1'b0;
                  end
               end
               if (ent[i].busy && ent[i].qk_busy) begin
                  if (ALU_CDB_sgn && ent[i].qk == ALU_CDB_ROB_name) begin
                     ent[i].vk      <= ALU_CDB_result;
                     ent[i].qk_busy <= 1'b0;
                  end else if (LSB_CDB_sgn && ent[i].qk == LSB_CDB_ROB_name) begin
                     ent[i].vk      <= LSB_CDB_result;
                     ent[i].qk_busy <= 1'b0;
                  end
               end
            end
            ALU_sgn <= has_ready;
            if (has_ready) begin
               ALU_opcode        <= ent[iss_idx].opcode;
               ALU_ROB_name      <= ent[iss_idx].rob_name;
               ALU_lhs           <= ent[iss_idx].vj;
               ALU_rhs           <= ent[iss_idx].vk;
               ent[iss_idx].busy <= 1'b0;
            end
            if (DP_sgn && !full) begin
               ent[free_idx] <= '{busy: 1'b1, opcode: DP_opcode,
                                  rob_name: DP_ROB_name,
                                  qj_busy: dj_busy, qj: DP_Qj, vj: dj_val,
                                  qk_busy: dk_busy, qk: DP_Qk, vk: dk_val};
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch, CDB wakeup, issue order,
// full handling, freeze and flush.
module tb_alu_rs;

   localparam logic [5:0] OP_ADDI = 6'd12;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd7;
   localparam logic [5:0] OP_JALR = 6'd37;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        DP_sgn;
   logic [5:0]  DP_opcode;
   logic [3:0]  DP_ROB_name;
   logic        DP_Qj_busy;
   logic [3:0]  DP_Qj;
   logic [31:0] DP_Vj;
   logic        DP_Qk_busy;
   logic [3:0]  DP_Qk;
   logic [31:0] DP_Vk;
   logic        full;
   logic        ALU_CDB_sgn;
   logic [3:0]  ALU_CDB_ROB_name;
   logic [31:0] ALU_CDB_result;
   logic        LSB_CDB_sgn;
   logic [3:0]  LSB_CDB_ROB_name;
   logic [31:0] LSB_CDB_result;
   logic        ALU_sgn;
   logic [5:0]  ALU_opcode;
   logic [3:0]  ALU_ROB_name;
   logic [31:0] ALU_lhs;
   logic [31:0] ALU_rhs;

   int n_assert = 0;
   int n_fail   = 0;

   alu_rs dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .DP_sgn(DP_sgn), .DP_opcode(DP_opcode), .DP_ROB_name(DP_ROB_name),
      .DP_Qj_busy(DP_Qj_busy), .DP_Qj(DP_Qj), .DP_Vj(DP_Vj),
      .DP_Qk_busy(DP_Qk_busy), .DP_Qk(DP_Qk), .DP_Vk(DP_Vk),
      .full(full),
      .ALU_CDB_sgn(ALU_CDB_sgn), .ALU_CDB_ROB_name(ALU_CDB_ROB_name),
      .ALU_CDB_result(ALU_CDB_result),
      .LSB_CDB_sgn(LSB_CDB_sgn), .LSB_CDB_ROB_name(LSB_CDB_ROB_name),
      .LSB_CDB_result(LSB_CDB_result),
      .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode),
      .ALU_ROB_name(ALU_ROB_name), .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      DP_sgn      = 1'b0;
      DP_Qj_busy  = 1'b0;
      DP_Qk_busy  = 1'b0;
      ALU_CDB_sgn = 1'b0;
      LSB_CDB_sgn = 1'b0;
      clear       = 1'b0;
   endtask

   task automatic dp(input logic [5:0] op, input logic [3:0] rob,
                     input logic jb, input logic [3:0] qj,
                     input logic [31:0] vj, input logic kb,
                     input logic [3:0] qk, input logic [31:0] vk);
      DP_sgn      = 1'b1;
      DP_opcode   = op;
      DP_ROB_name = rob;
      DP_Qj_busy  = jb;
      DP_Qj       = qj;
      DP_Vj       = vj;
      DP_Qk_busy  = kb;
      DP_Qk       = qk;
      DP_Vk       = vk;
   endtask

   task automatic acdb(input logic [3:0] tag, input logic [31:0] res);
      ALU_CDB_sgn      = 1'b1;
      ALU_CDB_ROB_name = tag;
      ALU_CDB_result   = res;
   endtask

   task automatic lcdb(input logic [3:0] tag, input logic [31:0] res);
      LSB_CDB_sgn      = 1'b1;
      LSB_CDB_ROB_name = tag;
      LSB_CDB_result   = res;
   endtask

   task automatic chk_issue(input string tag, input logic [5:0] op,
                            input logic [3:0] rob, input logic [31:0] l,
                            input logic [31:0] r);
      chk({tag, "_sgn"}, 32'(ALU_sgn), 32'd1);
      chk({tag, "_op"},  32'(ALU_opcode), 32'(op));
      chk({tag, "_rob"}, 32'(ALU_ROB_name), 32'(rob));
      chk({tag, "_lhs"}, ALU_lhs, l);
      chk({tag, "_rhs"}, ALU_rhs, r);
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      DP_opcode = '0; DP_ROB_name = '0; DP_Qj = '0; DP_Vj = '0;
      DP_Qk = '0; DP_Vk = '0;
      ALU_CDB_ROB_name = '0; ALU_CDB_result = '0;
      LSB_CDB_ROB_name = '0; LSB_CDB_result = '0;
      idle();

      // reset with a ready dispatch asserted
      dp(OP_ADDI, 4'd1, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd9);
      tick();
      tick();
      chk("rst_sgn", 32'(ALU_sgn), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_lhs", ALU_lhs, 32'd0);
      chk("rst_rob", 32'(ALU_ROB_name), 32'd0);
      rst = 1'b1;
      idle();
      tick();
      chk("post_rst_a", 32'(ALU_sgn), 32'd0);
      tick();
      chk("post_rst_b", 32'(ALU_sgn), 32'd0);

      // ready ADDI issues one cycle after dispatch
      dp(OP_ADDI, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
      tick();
      idle();
      chk("addi_dp_edge", 32'(ALU_sgn), 32'd0);
      tick();
      chk_issue("addi", OP_ADDI, 4'd3, 32'd5, 32'd7);
      tick();
      chk("addi_pulse_end", 32'(ALU_sgn), 32'd0);
      chk("addi_hold_lhs", ALU_lhs, 32'd5);

      // SUB waiting on tag 6, woken by ALU CDB
      dp(OP_SUB, 4'd2, 1'b1, 4'd6, 32'hdead, 1'b0, 4'd0, 32'd1);
      tick();
      idle();
      tick();
      chk("sub_wait", 32'(ALU_sgn), 32'd0);
      acdb(4'd6, 32'd10);
      tick();
      idle();
      chk("sub_wake_edge", 32'(ALU_sgn), 32'd0);
      tick();
      chk_issue("sub", OP_SUB, 4'd2, 32'd10, 32'd1);

      // same-cycle LSB broadcast captured at dispatch
      dp(OP_AND, 4'd5, 1'b0, 4'd0, 32'd3, 1'b1, 4'd4, 32'hbeef);
      lcdb(4'd4, 32'h80);
      tick();
      idle();
      tick();
      chk_issue("byp", OP_AND, 4'd5, 32'd3, 32'h80);

      // both sources woken in one cycle by different CDBs
      dp(OP_SUB, 4'd7, 1'b1, 4'd11, 32'd0, 1'b1, 4'd12, 32'd0);
      tick();
      idle();
      acdb(4'd11, 32'd100);
      lcdb(4'd12, 32'd42);
      tick();
      idle();
      tick();
      chk_issue("dual", OP_SUB, 4'd7, 32'd100, 32'd42);

      // rdy low freezes state and ignores inputs
      rdy = 1'b0;
      dp(OP_ADDI, 4'd8, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
      tick();
      idle();
      tick();
      chk("frz_sgn_hold", 32'(ALU_sgn), 32'd1);
      rdy = 1'b1;
      tick();
      chk("frz_no_issue", 32'(ALU_sgn), 32'd0);

      // fill all 16 entries; entry 0 waits on tag 1, rest on tag 9
      for (int i = 0; i < 16; i++) begin
         dp(OP_JALR, 4'(i), 1'b1, (i == 0) ? 4'd1 : 4'd9, 32'd0,
            1'b0, 4'd0, 32'd100 + 32'(i));
         tick();
      end
      idle();
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_sgn", 32'(ALU_sgn), 32'd0);
      dp(OP_ADDI, 4'd15, 1'b0, 4'd0, 32'd77, 1'b0, 4'd0, 32'd88);
      tick();
      idle();
      tick();
      chk("drop_no_issue", 32'(ALU_sgn), 32'd0);
      chk("drop_full", 32'(full), 32'd1);
      acdb(4'd1, 32'd50);
      tick();
      idle();
      chk("wake0_full", 32'(full), 32'd1);
      tick();
      chk_issue("wake0", OP_JALR, 4'd0, 32'd50, 32'd100);
      chk("wake0_free", 32'(full), 32'd0);
      tick();
      chk("wake0_once", 32'(ALU_sgn), 32'd0);

      // flush remaining entries
      clear = 1'b1;
      tick();
      idle();
      chk("flush_full", 32'(full), 32'd0);
      acdb(4'd9, 32'd1);
      tick();
      idle();
      tick();
      chk("flush_no_issue", 32'(ALU_sgn), 32'd0);

      // three waiters, then clear with a simultaneous ready dispatch
      dp(OP_SUB, 4'd1, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd1);
      tick();
      dp(OP_SUB, 4'd2, 1'b0, 4'd0, 32'd1, 1'b1, 4'd8, 32'd0);
      tick();
      dp(OP_SUB, 4'd3, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd1);
      tick();
      dp(OP_ADDI, 4'd4, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
      clear = 1'b1;
      tick();
      idle();
      chk("clr_sgn", 32'(ALU_sgn), 32'd0);
      chk("clr_full", 32'(full), 32'd0);
      tick();
      chk("clr_drop_dp", 32'(ALU_sgn), 32'd0);
      acdb(4'd7, 32'd5);
      lcdb(4'd8, 32'd6);
      tick();
      idle();
      acdb(4'd10, 32'd7);
      tick();
      idle();
      chk("clr_no_issue_a", 32'(ALU_sgn), 32'd0);
      tick();
      chk("clr_no_issue_b", 32'(ALU_sgn), 32'd0);

      // station still usable after flush
      dp(OP_AND, 4'd9, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd6);
      tick();
      idle();
      tick();
      chk_issue("reuse", OP_AND, 4'd9, 32'd4, 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
